// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: buffers user frames in a small circular FIFO and, on a
// drain request, clears the switch FIFOs and then releases the queued frames
// one per time slot. At most one end device is serializing at any moment.
module tx_frame_scheduler #(
  parameter int DEPTH       = 4,
  parameter int NUM_PORTS   = 4,
  parameter int FRAME_W     = 16,
  parameter int SLOT_CYCLES = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  input  logic [FRAME_W-1:0]         enq_frame,
  input  logic [1:0]                 enq_src,
  input  logic                       send_req,
  output logic [FRAME_W-1:0]         frame_out,
  output logic [NUM_PORTS-1:0]       tx_valid,
  output logic                       sw_clear,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       drain_done
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int SLOT_W = $clog2(SLOT_CYCLES);
  localparam int ENT_W  = FRAME_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [SLOT_W-1:0]  slot_cnt;
  logic [CNT_W-1:0]   next_count;
  logic               push;
  logic               pop;
  logic [ENT_W-1:0]   head;
  logic [1:0]         head_src;

  assign head     = mem[rd_ptr];
  assign head_src = head[ENT_W-1:FRAME_W];

  // Next-state logic; the head entry is popped on the edge that enters ISSUE
  // so the strobe and the count decrement become visible together.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    push       = enq_valid && !full;
    case (state)
      IDLE:    if (send_req) next_state = CLEAR;
      CLEAR:   next_state = (count != '0) ? ISSUE : DONE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (slot_cnt == '0) next_state = (count != '0) ? ISSUE : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    pop = (next_state == ISSUE);
    next_count = count;
    if (push && !pop) next_count = count + CNT_W'(1);
    else if (pop && !push) next_count = count - CNT_W'(1);
  end

  // Queue storage; contents need no reset because occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enq_src, enq_frame};
  end

  // Queue pointers and occupancy flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= next_count;
      full  <= (next_count == CNT_W'(DEPTH));
      empty <= (next_count == '0);
    end
  end

  // State register and slot counter pacing successive issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      slot_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ISSUE) slot_cnt <= SLOT_W'(SLOT_CYCLES - 2);
      else if (state == WAIT && slot_cnt != '0) slot_cnt <= slot_cnt - SLOT_W'(1);
    end
  end

  // Registered outputs derived from the upcoming state and queue activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_out  <= '0;
      tx_valid   <= '0;
      sw_clear   <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      sw_clear   <= (next_state == CLEAR);
      drain_done <= (next_state == DONE);
      busy       <= (next_state != IDLE);
      overflow   <= enq_valid && full;
      tx_valid   <= '0;
      if (pop) begin
        frame_out <= head[FRAME_W-1:0];
        if (int'(head_src) < NUM_PORTS) tx_valid <= NUM_PORTS'(1) << head_src;
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Testbench for tx_frame_scheduler: directed scenarios plus random traffic,
// every cycle compared against a timestamp-based reference model.
module tb_tx_frame_scheduler;

  localparam int DEPTH   = 4;
  localparam int NPORTS  = 4;
  localparam int FRAME_W = 16;
  localparam int SLOT    = 24;

  logic               clk = 1'b0;
  logic               rst;
  logic               enq_valid;
  logic [FRAME_W-1:0] enq_frame;
  logic [1:0]         enq_src;
  logic               send_req;
  logic [FRAME_W-1:0] frame_out;
  logic [NPORTS-1:0]  tx_valid;
  logic               sw_clear;
  logic               busy;
  logic [2:0]         count;
  logic               full;
  logic               empty;
  logic               overflow;
  logic               drain_done;

  int checks = 0;
  int errors = 0;

  // Reference model state: queue contents plus the cycle of the next decision.
  logic [17:0] mq[$];
  bit          m_busy;
  bit          m_ending;
  longint      decide_at;
  longint      cyc;
  logic [15:0] m_frame;
  logic [3:0]  m_tx;
  bit          m_clear;
  bit          m_done;
  bit          m_ovf;

  tx_frame_scheduler #(
    .DEPTH(DEPTH), .NUM_PORTS(NPORTS), .FRAME_W(FRAME_W), .SLOT_CYCLES(SLOT)
  ) dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_frame(enq_frame),
    .enq_src(enq_src), .send_req(send_req), .frame_out(frame_out),
    .tx_valid(tx_valid), .sw_clear(sw_clear), .busy(busy), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .drain_done(drain_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_busy = 0; m_ending = 0; decide_at = 0;
    m_frame = '0; m_tx = '0; m_clear = 0; m_done = 0; m_ovf = 0;
  endtask

  // One clock edge of the reference: decisions happen at scheduled cycles.
  task automatic modelStep();
    int s;
    bit was_idle;
    logic [17:0] e;
    s = mq.size();
    was_idle = !m_busy;
    m_tx = '0; m_clear = 0; m_done = 0;
    m_ovf = enq_valid && (s == DEPTH);
    if (m_busy && m_ending) begin
      m_busy = 0;
      m_ending = 0;
    end else if (m_busy && cyc == decide_at) begin
      if (s > 0) begin
        e = mq.pop_front();
        m_frame = e[15:0];
        m_tx = 4'b0001 << e[17:16];
        decide_at = cyc + SLOT;
      end else begin
        m_done = 1;
        m_ending = 1;
      end
    end
    if (enq_valid && s < DEPTH) mq.push_back({enq_src, enq_frame});
    if (was_idle && send_req) begin
      m_busy = 1;
      m_clear = 1;
      decide_at = cyc + 1;
    end
  endtask

  task automatic checkAll();
    checkOutput("frame_out", 32'(frame_out), 32'(m_frame));
    checkOutput("tx_valid", 32'(tx_valid), 32'(m_tx));
    checkOutput("sw_clear", 32'(sw_clear), 32'(m_clear));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("count", 32'(count), 32'(mq.size()));
    checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
    checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("drain_done", 32'(drain_done), 32'(m_done));
  endtask

  task automatic applyStimulus(input bit ev, input logic [15:0] fr, input logic [1:0] src, input bit sr);
    enq_valid = ev; enq_frame = fr; enq_src = src; send_req = sr;
    @(posedge clk);
    cyc++;
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 16'h0, 2'd0, 0);
  endtask

  task automatic drainToIdle();
    applyStimulus(0, 16'h0, 2'd0, 1);
    for (int i = 0; i < 400 && m_busy; i++) applyStimulus(0, 16'h0, 2'd0, 0);
    checkOutput("drain_end_busy", 32'(busy), 32'(0));
  endtask

  task automatic asyncReset();
    rst = 1'b1;
    #2;
    modelReset();
    checkAll();
    @(posedge clk);
    cyc++;
    #1;
    checkAll();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enq_valid = 0; enq_frame = '0; enq_src = '0; send_req = 0;
    cyc = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    rst = 1'b0;

    $display("[TB] reset and empty drain");
    drainToIdle();
    runIdle(2);

    $display("[TB] order and pacing");
    applyStimulus(1, 16'hA5C3, 2'd0, 0);
    applyStimulus(1, 16'h5BA7, 2'd1, 0);
    applyStimulus(1, 16'h5DC1, 2'd3, 0);
    drainToIdle();
    runIdle(2);

    $display("[TB] overflow");
    for (int i = 0; i < 5; i++) applyStimulus(1, 16'h1000 + 16'(i), 2'(i), 0);
    drainToIdle();
    runIdle(2);

    $display("[TB] enqueue during drain");
    applyStimulus(1, 16'hC001, 2'd2, 0);
    applyStimulus(1, 16'hC002, 2'd1, 0);
    applyStimulus(0, 16'h0, 2'd0, 1);
    applyStimulus(1, 16'hC0DE, 2'd3, 0);
    applyStimulus(0, 16'h0, 2'd0, 0);
    applyStimulus(1, 16'hC003, 2'd0, 0);
    for (int i = 0; i < 400 && m_busy; i++) applyStimulus(0, 16'h0, 2'd0, 0);
    checkOutput("enq_drain_end_busy", 32'(busy), 32'(0));

    $display("[TB] pointer wrap");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) applyStimulus(1, 16'($urandom), 2'($urandom_range(0, 3)), 0);
      drainToIdle();
    end

    $display("[TB] reset mid-drain");
    for (int i = 0; i < 3; i++) applyStimulus(1, 16'hD000 + 16'(i), 2'(i), 0);
    applyStimulus(0, 16'h0, 2'd0, 1);
    runIdle(6);
    asyncReset();
    runIdle(60);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 2) == 0, 16'($urandom), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 19) == 0);
    for (int i = 0; i < 400 && m_busy; i++) applyStimulus(0, 16'h0, 2'd0, 0);
    checkOutput("final_busy", 32'(busy), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
